// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD combinational read ports, two write ports (wr1 wins on collision),
// hardware clear sweep after reset or on clr_req. Optional write-to-read forwarding: REGFILE_BYPASS_EN.

module regfile_mp_rdport #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] mem,
  input  logic [ADDR_W-1:0]                  addr,
  input  logic                               busy,
  input  logic                               byp_vld,
  input  logic [DATA_W-1:0]                  byp_data,
  output logic [DATA_W-1:0]                  data
);
  always_comb begin
    data = mem[addr];
    if (byp_vld) data = byp_data;
    // busy and the hardwired zero entry override any forwarded value
    if (busy || (ZERO_REG != 0 && addr == '0)) data = '0;
  end
endmodule

module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr_req,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  input  logic                       wr0_en,
  input  logic [ADDR_W-1:0]          wr0_addr,
  input  logic [DATA_W-1:0]          wr0_data,
  input  logic                       wr1_en,
  input  logic [ADDR_W-1:0]          wr1_addr,
  input  logic [DATA_W-1:0]          wr1_data,
  output logic                       busy
);
  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t                         state, state_nxt;
  logic [ADDR_W-1:0]              clr_ptr, clr_ptr_nxt;
  logic [DEPTH-1:0][DATA_W-1:0]   mem;
  logic                           idle, wr0_ok, wr1_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_ptr <= '0;
    end else begin
      state   <= state_nxt;
      clr_ptr <= clr_ptr_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_ptr_nxt = clr_ptr;
    case (state)
      CLEAR: begin
        clr_ptr_nxt = clr_ptr + 1'b1;
        if (clr_ptr == ADDR_W'(DEPTH-1)) state_nxt = IDLE;
      end
      IDLE: begin
        if (clr_req) begin
          state_nxt   = CLEAR;
          clr_ptr_nxt = '0;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  assign busy   = (state == CLEAR);
  assign idle   = (state == IDLE);
  assign wr0_ok = idle && wr0_en && !(ZERO_REG != 0 && wr0_addr == '0);
  assign wr1_ok = idle && wr1_en && !(ZERO_REG != 0 && wr1_addr == '0);

  // Storage has no reset; the sweep is what zeroes it. wr1 is assigned last so it wins a collision.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      if (state == CLEAR) begin
        mem[clr_ptr] <= '0;
      end else begin
        if (wr0_ok) mem[wr0_addr] <= wr0_data;
        if (wr1_ok) mem[wr1_addr] <= wr1_data;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              byp_vld;
    logic [DATA_W-1:0] byp_data;

    assign ra = rd_addr[k*ADDR_W +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
    assign byp_vld  = (wr1_ok && wr1_addr == ra) || (wr0_ok && wr0_addr == ra);
    assign byp_data = (wr1_ok && wr1_addr == ra) ? wr1_data : wr0_data;
`else
    assign byp_vld  = 1'b0;
    assign byp_data = '0;
`endif

    regfile_mp_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rd (
      .mem      (mem),
      .addr     (ra),
      .busy     (busy),
      .byp_vld  (byp_vld),
      .byp_data (byp_data),
      .data     (rd_data[k*DATA_W +: DATA_W])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp; dut has ZERO_REG=1, dut_z0 has ZERO_REG=0 and shares all inputs.
module tb_regfile_mp;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NUM_RD = 2;

  logic                     clk = 1'b0;
  logic                     rst_n, clr_req;
  logic [NUM_RD*ADDR_W-1:0] rd_addr;
  logic [NUM_RD*DATA_W-1:0] rd_data, rd_data_z0;
  logic                     wr0_en, wr1_en;
  logic [ADDR_W-1:0]        wr0_addr, wr1_addr;
  logic [DATA_W-1:0]        wr0_data, wr1_data;
  logic                     busy, busy_z0;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(1)) dut (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .busy(busy));

  regfile_mp #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_RD(NUM_RD), .ZERO_REG(0)) dut_z0 (
    .clk(clk), .rst_n(rst_n), .clr_req(clr_req), .rd_addr(rd_addr), .rd_data(rd_data_z0),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data), .busy(busy_z0));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_idle();
    wr0_en = 1'b0;
    wr1_en = 1'b0;
  endtask

  // counts cycles until busy drops, bounded
  task automatic busy_len(output int n);
    n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
  endtask

  task automatic check_all_zero(input string name);
    int bad;
    bad = 0;
    for (int a = 0; a < 32; a++) begin
      rd_addr = {ADDR_W'(31 - a), ADDR_W'(a)};
      #1;
      if (rd_data !== 64'h0 || rd_data_z0 !== 64'h0) bad++;
    end
    nvec++;
    if (bad != 0) begin
      nerr++;
      $display("FAIL %s: %0d entries nonzero, required 0", name, bad);
    end
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    repeat (3) step();
    nvec++;
    if (busy !== 1'b1 || rd_data !== 64'h0) begin
      nerr++;
      $display("FAIL reset_busy: busy=%b rd=%h, required busy=1 rd=0", busy, rd_data);
    end
    rst_n    = 1'b1;
    wr0_en   = 1'b1;
    wr0_addr = 5'd5;
    wr0_data = 32'hDEADBEEF;
    busy_len(n);
    wr_idle();
    nvec++;
    if (n != 32) begin
      nerr++;
      $display("FAIL reset_sweep_len: %0d cycles, required 32", n);
    end
    nvec++;
    if (busy_z0 !== 1'b0) begin
      nerr++;
      $display("FAIL reset_busy_z0: %b, required 0", busy_z0);
    end
    check_all_zero("reset_all_zero");
  endtask

  task automatic test_dual_write();
    wr0_en = 1'b1; wr0_addr = 5'd3; wr0_data = 32'h12345678;
    wr1_en = 1'b1; wr1_addr = 5'd7; wr1_data = 32'hCAFEF00D;
    step();
    wr_idle();
    rd_addr = {5'd7, 5'd3};
    #1;
    nvec++;
    if (rd_data !== 64'hCAFEF00D_12345678) begin
      nerr++;
      $display("FAIL dual_write: %h, required cafef00d12345678", rd_data);
    end
  endtask

  task automatic test_collision();
    wr0_en = 1'b1; wr0_addr = 5'd9; wr0_data = 32'h11111111;
    wr1_en = 1'b1; wr1_addr = 5'd9; wr1_data = 32'h22222222;
    step();
    wr_idle();
    rd_addr = {5'd9, 5'd9};
    #1;
    nvec++;
    if (rd_data !== 64'h22222222_22222222) begin
      nerr++;
      $display("FAIL collision: %h, required 2222222222222222", rd_data);
    end
  endtask

  task automatic test_zero_reg();
    wr0_en = 1'b1; wr0_addr = 5'd0; wr0_data = 32'hFFFFFFFF;
    step();
    wr_idle();
    rd_addr = {5'd3, 5'd0};
    #1;
    nvec++;
    if (rd_data[31:0] !== 32'h0) begin
      nerr++;
      $display("FAIL zero_reg1: %h, required 0", rd_data[31:0]);
    end
    nvec++;
    if (rd_data_z0[31:0] !== 32'hFFFFFFFF) begin
      nerr++;
      $display("FAIL zero_reg0: %h, required ffffffff", rd_data_z0[31:0]);
    end
  endtask

  task automatic test_rdw();
    logic [31:0] exp_now;
`ifdef REGFILE_BYPASS_EN
    exp_now = 32'hA5A5A5A5;
`else
    exp_now = 32'h0;
`endif
    rd_addr = {5'd7, 5'd4};
    wr0_en = 1'b1; wr0_addr = 5'd4; wr0_data = 32'hA5A5A5A5;
    #1;
    nvec++;
    if (rd_data[31:0] !== exp_now) begin
      nerr++;
      $display("FAIL rdw_same_cycle: %h, required %h", rd_data[31:0], exp_now);
    end
    nvec++;
    if (rd_data[63:32] !== 32'hCAFEF00D) begin
      nerr++;
      $display("FAIL rdw_other_port: %h, required cafef00d", rd_data[63:32]);
    end
    step();
    wr_idle();
    #1;
    nvec++;
    if (rd_data[31:0] !== 32'hA5A5A5A5) begin
      nerr++;
      $display("FAIL rdw_next_cycle: %h, required a5a5a5a5", rd_data[31:0]);
    end
  endtask

  task automatic test_clear();
    int n;
    for (int a = 1; a < 32; a++) begin
      wr0_en = 1'b1; wr0_addr = ADDR_W'(a); wr0_data = 32'h1000_0000 + 32'(a);
      step();
    end
    wr_idle();
    rd_addr = {5'd31, 5'd1};
    #1;
    nvec++;
    if (rd_data !== 64'h1000001F_10000001) begin
      nerr++;
      $display("FAIL populate: %h, required 1000001f10000001", rd_data);
    end
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (5) step();
    clr_req = 1'b1;          // ignored mid-sweep
    busy_len(n);
    clr_req = 1'b0;
    nvec++;
    if (n != 27) begin
      nerr++;
      $display("FAIL clr_sweep_len: %0d cycles remaining after 5, required 27", n);
    end
    check_all_zero("clr_all_zero");

    wr0_en = 1'b1; wr0_addr = 5'd12; wr0_data = 32'h0BADF00D;
    step();
    wr_idle();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    repeat (10) step();
    rst_n = 1'b0;
    repeat (2) step();
    nvec++;
    if (busy !== 1'b1) begin
      nerr++;
      $display("FAIL midsweep_reset_busy: %b, required 1", busy);
    end
    rst_n = 1'b1;
    busy_len(n);
    nvec++;
    if (n != 32) begin
      nerr++;
      $display("FAIL midsweep_restart_len: %0d cycles, required 32", n);
    end
    check_all_zero("midsweep_all_zero");
  endtask

  initial begin
    rst_n = 1'b0; clr_req = 1'b0; rd_addr = '0;
    wr0_en = 1'b0; wr0_addr = '0; wr0_data = '0;
    wr1_en = 1'b0; wr1_addr = '0; wr1_data = '0;
    #1;
    test_reset();
    test_dual_write();
    test_collision();
    test_zero_reg();
    test_rdw();
    test_clear();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
